// File: rtl/conv_pkg.sv
// Shared definitions for the systolic-core instruction sequencer: state encoding,
// instruction-word bit map and default array geometry.
package conv_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_WR,
    S_W_LOAD,
    S_GAP,
    S_A_WR,
    S_EXEC,
    S_DRAIN,
    S_OF_RD,
    S_ACC_CLR,
    S_ACC_RD,
    S_ACC_OUT,
    S_DONE
  } state_t;

  localparam int INST_W    = 34;
  localparam int A_W       = 11;
  localparam int CNT_W     = 6;

  localparam int B_ACC     = 33;
  localparam int B_CEN_P   = 32;
  localparam int B_WEN_P   = 31;
  localparam int B_AP_LSB  = 20;
  localparam int B_CEN_X   = 19;
  localparam int B_WEN_X   = 18;
  localparam int B_AX_LSB  = 7;
  localparam int B_OFIFO_RD = 6;
  localparam int B_IFIFO_WR = 5;
  localparam int B_IFIFO_RD = 4;
  localparam int B_L0_RD   = 3;
  localparam int B_L0_WR   = 2;
  localparam int B_EXEC    = 1;
  localparam int B_LOAD    = 0;

  // Both memories deselected and write-disabled; every strobe low.
  localparam logic [INST_W-1:0] IDLE_INST = 34'h1_800C_0000;

  localparam int DEF_ROW      = 8;
  localparam int DEF_COL      = 8;
  localparam int DEF_LEN_NIJ  = 36;
  localparam int DEF_LEN_KIJ  = 9;
  localparam int DEF_LEN_ONIJ = 16;
  localparam int DEF_GAP      = 2;
  localparam logic [A_W-1:0] DEF_W_BASE = 11'h400;

endpackage

// File: rtl/phase_counter.sv
// Loadable down-counter that times each sequencer phase; o_tc flags the last cycle.
module phase_counter
  import conv_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == '0);

endmodule

// File: rtl/conv_sequencer.sv
// Instruction sequencer for the 2D systolic core: per-kernel-position load/execute/drain
// passes followed by per-output accumulation over pmem, all on a registered inst word.
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int             row      = DEF_ROW,
  parameter int             col      = DEF_COL,
  parameter int             len_nij  = DEF_LEN_NIJ,
  parameter int             len_kij  = DEF_LEN_KIJ,
  parameter int             len_onij = DEF_LEN_ONIJ,
  parameter int             gap      = DEF_GAP,
  parameter logic [A_W-1:0] W_BASE   = DEF_W_BASE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ofifo_valid,
  input  logic [A_W-1:0]    acc_addr,
  output logic [INST_W-1:0] inst,
  output logic [3:0]        acc_onij,
  output logic [3:0]        acc_kij,
  output logic              acc_clr,
  output logic              out_valid,
  output logic [3:0]        out_idx,
  output logic              busy,
  output logic              done,
  output state_t            dbg_state
);

  localparam logic [CNT_W-1:0] LAST_COL   = CNT_W'(col - 1);
  localparam logic [CNT_W-1:0] LAST_GAP   = CNT_W'(gap - 1);
  localparam logic [CNT_W-1:0] LAST_NIJ   = CNT_W'(len_nij - 1);
  localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(row + col - 1);
  localparam logic [CNT_W-1:0] LAST_ACC   = CNT_W'(len_kij);
  localparam logic [3:0]       LAST_KIJ   = 4'(len_kij - 1);
  localparam logic [3:0]       LAST_ONIJ  = 4'(len_onij - 1);

  state_t             r_state, w_next;
  logic [3:0]         r_kij, r_onij, r_acc_kij, r_out_idx;
  logic [INST_W-1:0]  r_inst, w_inst;
  logic               r_acc_clr, r_out_valid, r_busy, r_done;
  logic               w_load, w_en, w_tc;
  logic [CNT_W-1:0]   w_load_val, w_cnt, w_last, w_i;
  logic               w_kij_clr, w_kij_inc, w_onij_clr, w_onij_inc;

  phase_counter #(.W(CNT_W)) u_phase (
    .clk        (clk),
    .rst_n      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_en       (w_en),
    .o_count    (w_cnt),
    .o_tc       (w_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // OFIFO handshake: ofifo_valid is the core's valid, ofifo_rd in the emitted word is
  // the ready/pop; a row transfers only in a cycle where both are 1, so i steps only then.
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = '0;
    w_en       = 1'b1;
    w_kij_clr  = 1'b0;
    w_kij_inc  = 1'b0;
    w_onij_clr = 1'b0;
    w_onij_inc = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_en = 1'b0;
        if (start) begin
          w_next = S_W_WR; w_load = 1'b1; w_load_val = LAST_COL; w_kij_clr = 1'b1;
        end
      end
      S_W_WR:   if (w_tc) begin w_next = S_W_LOAD; w_load = 1'b1; w_load_val = LAST_COL;   end
      S_W_LOAD: if (w_tc) begin w_next = S_GAP;    w_load = 1'b1; w_load_val = LAST_GAP;   end
      S_GAP:    if (w_tc) begin w_next = S_A_WR;   w_load = 1'b1; w_load_val = LAST_NIJ;   end
      S_A_WR:   if (w_tc) begin w_next = S_EXEC;   w_load = 1'b1; w_load_val = LAST_NIJ;   end
      S_EXEC:   if (w_tc) begin w_next = S_DRAIN;  w_load = 1'b1; w_load_val = LAST_DRAIN; end
      S_DRAIN:  if (w_tc) begin w_next = S_OF_RD;  w_load = 1'b1; w_load_val = LAST_NIJ;   end
      S_OF_RD: begin
        w_en = ofifo_valid;
        if (w_tc && ofifo_valid) begin
          if (r_kij < LAST_KIJ) begin
            w_next = S_W_WR; w_load = 1'b1; w_load_val = LAST_COL; w_kij_inc = 1'b1;
          end else begin
            w_next = S_ACC_CLR; w_onij_clr = 1'b1;
          end
        end
      end
      S_ACC_CLR: begin
        w_en = 1'b0; w_next = S_ACC_RD; w_load = 1'b1; w_load_val = LAST_ACC;
      end
      S_ACC_RD: if (w_tc) w_next = S_ACC_OUT;
      S_ACC_OUT: begin
        w_en = 1'b0;
        if (r_onij < LAST_ONIJ) begin
          w_next = S_ACC_CLR; w_onij_inc = 1'b1;
        end else begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_en = 1'b0; w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Phase index i counts up while the counter counts down from the phase's last value.
  always_comb begin
    w_last = '0;
    case (r_state)
      S_W_WR, S_W_LOAD:       w_last = LAST_COL;
      S_A_WR, S_EXEC, S_OF_RD: w_last = LAST_NIJ;
      S_ACC_RD:               w_last = LAST_ACC;
      default:                w_last = '0;
    endcase
    w_i = w_last - w_cnt;
  end

  always_comb begin
    w_inst = IDLE_INST;
    case (r_state)
      S_W_WR: begin
        w_inst[B_CEN_X] = 1'b0;
        w_inst[B_L0_WR] = 1'b1;
        w_inst[B_AX_LSB +: A_W] = W_BASE + A_W'(r_kij) * A_W'(col) + A_W'(w_i);
      end
      S_W_LOAD: begin
        w_inst[B_L0_RD] = 1'b1;
        w_inst[B_LOAD]  = 1'b1;
      end
      S_A_WR: begin
        w_inst[B_CEN_X] = 1'b0;
        w_inst[B_L0_WR] = 1'b1;
        w_inst[B_AX_LSB +: A_W] = A_W'(w_i);
      end
      S_EXEC: begin
        w_inst[B_L0_RD] = 1'b1;
        w_inst[B_EXEC]  = 1'b1;
      end
      S_DRAIN: w_inst[B_EXEC] = 1'b1;
      S_OF_RD: begin
        if (ofifo_valid) begin
          w_inst[B_OFIFO_RD] = 1'b1;
          w_inst[B_CEN_P]    = 1'b0;
          w_inst[B_WEN_P]    = 1'b0;
          w_inst[B_AP_LSB +: A_W] = A_W'(r_kij) * A_W'(len_nij) + A_W'(w_i);
        end
      end
      S_ACC_RD: begin
        // acc trails each pmem read by one cycle to line up with read latency.
        if (w_i < CNT_W'(len_kij)) begin
          w_inst[B_CEN_P] = 1'b0;
          w_inst[B_AP_LSB +: A_W] = acc_addr;
        end
        if (w_i != '0) w_inst[B_ACC] = 1'b1;
      end
      default: w_inst = IDLE_INST;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_kij       <= '0;
      r_onij      <= '0;
      r_acc_kij   <= '0;
      r_inst      <= IDLE_INST;
      r_acc_clr   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if (w_kij_clr)      r_kij <= '0;
      else if (w_kij_inc) r_kij <= r_kij + 4'd1;
      if (w_onij_clr)      r_onij <= '0;
      else if (w_onij_inc) r_onij <= r_onij + 4'd1;
      // acc_kij runs one cycle ahead of inst so acc_addr is ready when the word registers.
      if (r_state == S_ACC_CLR)
        r_acc_kij <= '0;
      else if ((r_state == S_ACC_RD) && (r_acc_kij < LAST_KIJ))
        r_acc_kij <= r_acc_kij + 4'd1;
      r_inst      <= w_inst;
      r_acc_clr   <= (r_state == S_ACC_CLR);
      r_out_valid <= (r_state == S_ACC_OUT);
      if (r_state == S_ACC_OUT) r_out_idx <= r_onij;
      r_busy      <= (w_next != S_IDLE);
      r_done      <= (w_next == S_DONE);
    end
  end

  assign inst      = r_inst;
  assign acc_onij  = r_onij;
  assign acc_kij   = r_acc_kij;
  assign acc_clr   = r_acc_clr;
  assign out_valid = r_out_valid;
  assign out_idx   = r_out_idx;
  assign busy      = r_busy;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_conv_sequencer.sv
// Self-checking bench for conv_sequencer: address/strobe scoreboard, cycle counts,
// OFIFO stall, ignored start, and mid-run reset with restart.
module tb_conv_sequencer;

  localparam int ROW = 8, COL = 8, NIJ = 36, KIJ = 9, ONIJ = 16, GAP = 2;
  localparam logic [10:0] WB     = 11'h400;
  localparam logic [33:0] IDLE_W = 34'h1_800C_0000;
  localparam int PASS    = 2*COL + GAP + 2*NIJ + ROW + COL + NIJ;
  localparam int RUN_CYC = KIJ*PASS + ONIJ*(KIJ + 3);
  localparam int RST_N   = 4*PASS + 2*COL + GAP + 2*NIJ + 7;

  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, ofifo_valid = 1'b1;
  logic [10:0] acc_addr;
  logic [33:0] inst;
  logic [3:0]  acc_onij, acc_kij, out_idx;
  logic        acc_clr, out_valid, busy, done;
  conv_pkg::state_t dbg_state;

  conv_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .ofifo_valid(ofifo_valid),
    .acc_addr(acc_addr), .inst(inst), .acc_onij(acc_onij), .acc_kij(acc_kij),
    .acc_clr(acc_clr), .out_valid(out_valid), .out_idx(out_idx),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  assign acc_addr = 11'(acc_kij) * 11'(NIJ) + 11'(acc_onij);

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  logic [10:0] exp_wq[$], exp_aq[$], exp_pq[$], exp_rq[$];
  logic [3:0]  exp_oq[$];
  int   n_bursts, n_outs, clr_age, aux_k, stall_at;
  logic mon_en = 1'b0;
  logic prev_rd, prev_wt, prev_acc, clr_pend, is_xw, is_wt, is_pw, is_pr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [33:0] wr_word(input logic [10:0] a);
    logic [33:0] w;
    w = IDLE_W;
    w[19] = 1'b0;
    w[2] = 1'b1;
    w[17:7] = a;
    return w;
  endfunction

  task automatic push_expect();
    for (int k = 0; k < KIJ; k++) begin
      for (int j = 0; j < COL; j++) exp_wq.push_back(WB + 11'(k*COL + j));
      for (int j = 0; j < NIJ; j++) begin
        exp_aq.push_back(11'(j));
        exp_pq.push_back(11'(k*NIJ + j));
      end
    end
    for (int o = 0; o < ONIJ; o++) begin
      exp_oq.push_back(4'(o));
      for (int k = 0; k < KIJ; k++) exp_rq.push_back(11'(k*NIJ + o));
    end
  endtask

  task automatic clear_q();
    exp_wq.delete(); exp_aq.delete(); exp_pq.delete(); exp_rq.delete(); exp_oq.delete();
  endtask

  // Monitor: pops the expected queues as the DUT emits matching words.
  always @(negedge clk) begin
    if (!reset || !mon_en) begin
      prev_rd = 1'b0; prev_wt = 1'b0; prev_acc = 1'b0; clr_pend = 1'b0; clr_age = 0;
    end else begin
      is_xw = !inst[19] && inst[2];
      is_wt = is_xw && (inst[17:7] >= WB);
      is_pw = !inst[32] && !inst[31];
      is_pr = !inst[32] && inst[31];
      if (is_wt) begin
        if (!prev_wt) n_bursts++;
        if (exp_wq.size() == 0) check("w_unexpected", 64'(inst[17:7]), 64'h0);
        else check("w_addr", 64'(inst[17:7]), 64'(exp_wq.pop_front()));
      end else if (is_xw) begin
        if (exp_aq.size() == 0) check("a_unexpected", 64'(inst[17:7]), 64'h0);
        else check("a_addr", 64'(inst[17:7]), 64'(exp_aq.pop_front()));
      end
      if (is_pw) begin
        check("pw_ofifo_rd", 64'(inst[6]), 64'h1);
        if (exp_pq.size() == 0) check("pw_unexpected", 64'(inst[30:20]), 64'h0);
        else check("pw_addr", 64'(inst[30:20]), 64'(exp_pq.pop_front()));
      end
      if (is_pr) begin
        if (exp_rq.size() == 0) check("pr_unexpected", 64'(inst[30:20]), 64'h0);
        else check("pr_addr", 64'(inst[30:20]), 64'(exp_rq.pop_front()));
      end
      if (prev_rd || inst[33]) check("acc_lag", 64'(inst[33]), 64'(prev_rd));
      if (acc_clr) begin
        clr_pend = 1'b1; clr_age = 0;
      end else if (clr_pend) begin
        clr_age++;
        if (inst[33]) begin
          check("clr_lead", 64'(clr_age), 64'd2);
          clr_pend = 1'b0;
        end
      end
      if (out_valid) begin
        n_outs++;
        check("ov_after_acc", 64'({prev_acc, inst[33]}), 64'h2);
        if (exp_oq.size() == 0) check("ov_unexpected", 64'(out_idx), 64'h0);
        else check("out_idx", 64'(out_idx), 64'(exp_oq.pop_front()));
      end
      prev_rd = is_pr; prev_wt = is_wt; prev_acc = inst[33];
    end
  end

  task automatic start_run();
    @(negedge clk);
    push_expect();
    n_bursts = 0; n_outs = 0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int exp_n);
    int n;
    n = -1;
    while (n < exp_n + 50) begin
      @(negedge clk);
      n++;
      if (n == 0) check("busy_rise", 64'(busy), 64'h1);
      if (n == 1) check("first_word", 64'(inst), 64'(wr_word(WB)));
      if (done) break;
    end
    check("done_cycle", 64'(n), 64'(exp_n));
    check("busy_at_done", 64'(busy), 64'h1);
    @(negedge clk);
    check("busy_fall", 64'(busy), 64'h0);
    check("done_pulse", 64'(done), 64'h0);
    check("w_bursts", 64'(n_bursts), 64'(KIJ));
    check("out_pulses", 64'(n_outs), 64'(ONIJ));
    check("left_w", 64'(exp_wq.size()), 64'h0);
    check("left_a", 64'(exp_aq.size()), 64'h0);
    check("left_pw", 64'(exp_pq.size()), 64'h0);
    check("left_pr", 64'(exp_rq.size()), 64'h0);
    check("left_ov", 64'(exp_oq.size()), 64'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held while the clock runs.
    repeat (3) @(negedge clk);
    check("rst_inst", 64'(inst), 64'(IDLE_W));
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_done", 64'(done), 64'h0);
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_acc_clr", 64'(acc_clr), 64'h0);
    repeat (2) @(negedge clk);
    check("rst_hold_inst", 64'(inst), 64'(IDLE_W));
    reset = 1'b1;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_inst", 64'(inst), 64'(IDLE_W));
    check("idle_busy", 64'(busy), 64'h0);

    // Full run, OFIFO always valid.
    start_run();
    wait_done(RUN_CYC);

    // OFIFO stall of 5 cycles in the middle of kij=2 readout.
    stall_at = 72 + $urandom_range(5, 25);
    start_run();
    fork
      wait_done(RUN_CYC + 5);
      begin
        aux_k = 0;
        while (aux_k < 2000 && !(!inst[32] && !inst[31] && inst[30:20] == 11'(stall_at))) begin
          @(negedge clk);
          aux_k++;
        end
        ofifo_valid = 1'b0;
        repeat (5) @(negedge clk);
        ofifo_valid = 1'b1;
      end
    join

    // start pulsed during EXEC is ignored.
    start_run();
    fork
      wait_done(RUN_CYC);
      begin
        aux_k = 0;
        while (aux_k < 2000 && !(inst[1] && inst[3])) begin
          @(negedge clk);
          aux_k++;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join

    // Reset during DRAIN of kij=4, then a clean restart.
    start_run();
    for (int k = 0; k <= RST_N; k++) @(negedge clk);
    check("in_drain", 64'(inst), 64'(IDLE_W | 34'h2));
    #1 reset = 1'b0;
    #1;
    check("midrst_inst", 64'(inst), 64'(IDLE_W));
    check("midrst_busy", 64'(busy), 64'h0);
    clear_q();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    start_run();
    wait_done(RUN_CYC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
